// File: rtl/mem_rmw_adapter.sv
// rtl/mem_rmw_adapter.sv - byte/halfword/word load-store adapter onto a word-wide memory, read-modify-write for sub-word stores
// Optional feature macro: RMW_ALIGN_CHECK_EN (reject misaligned halfword/word requests)
module mem_rmw_adapter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

    // Counter only ever reaches MAX_WAIT-1 before the timeout fires
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [WW-1:0] wait_q;
    logic [31:0]   addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          is_wr_q;
    logic [15:0]   st_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;

    logic          req;
    logic          misaligned;
    logic          bad_req;
    logic          timeout;
    logic          rd_ack;
    logic [7:0]    lane8;
    logic [15:0]   lane16;
    logic [31:0]   load_ext;
    logic [31:0]   merged;

    assign req = rd_en_i | wr_en_i;

`ifdef RMW_ALIGN_CHECK_EN
    assign misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                        ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign bad_req = (rd_en_i & wr_en_i) | (size_i == 2'b11) | misaligned;
    assign timeout = (wait_q == WW'(MAX_WAIT - 1));
    assign rd_ack  = (state_q == READ) && mem_ack_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: sub-word stores take the READ leg first, then WRITE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad_req) begin
                        state_d = ERR;
                    end else if (rd_en_i || (size_i != 2'b10)) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                if (mem_ack_i) begin
                    state_d = is_wr_q ? WRITE : DONE;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            WRITE: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded purely from state
    always_comb begin
        busy_o      = (state_q != IDLE);
        mem_rd_en_o = (state_q == READ);
        mem_wr_en_o = (state_q == WRITE);
        ack_o       = (state_q == DONE) || (state_q == ERR);
        err_o       = (state_q == ERR);
    end

    // Wait counter restarts on every state change, counts while stalled in READ/WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_d != state_q) begin
            wait_q <= '0;
        end else if ((state_q == READ) || (state_q == WRITE)) begin
            wait_q <= wait_q + WW'(1);
        end
    end

    // Request capture at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            is_wr_q <= 1'b0;
            st_q    <= '0;
        end else if ((state_q == IDLE) && req) begin
            addr_q  <= addr_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            is_wr_q <= wr_en_i;
            st_q    <= data_i[15:0];
        end
    end

    // Lane select and extension of the returned memory word
    always_comb begin
        lane8  = mem_data_i[{addr_q[1:0], 3'b000} +: 8];
        lane16 = mem_data_i[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane8[7]}}, lane8};
            2'b01:   load_ext = {{16{~uns_q & lane16[15]}}, lane16};
            default: load_ext = mem_data_i;
        endcase
    end

    // Merge store data into the addressed lane of the word just read
    always_comb begin
        merged = mem_data_i;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = st_q[7:0];
        end else if (size_q == 2'b01) begin
            merged[{addr_q[1], 4'b0000} +: 16] = st_q;
        end
    end

    // Outgoing write word: raw store data for word writes, merged word for RMW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_q <= '0;
        end else if ((state_q == IDLE) && req) begin
            wdata_q <= data_i;
        end else if (rd_ack && is_wr_q) begin
            wdata_q <= merged;
        end
    end

    // Load result held until the next completed read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_ack && !is_wr_q) begin
            rdata_q <= load_ext;
        end
    end

    assign data_o     = rdata_q;
    assign mem_addr_o = {addr_q[31:2], 2'b00};
    assign mem_data_o = wdata_q;

endmodule

// File: tb/tb_mem_rmw_adapter.sv
// tb/tb_mem_rmw_adapter.sv - self-checking bench for mem_rmw_adapter (vector table, directed corners, randomized vs byte-level model)
module tb_mem_rmw_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en_i;
    logic        wr_en_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;
    logic        busy_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    logic [31:0] mem [256];
    logic [7:0]  ref_b [1024];
    logic [31:0] ref_data;
    int          n_tests;
    int          n_fail;
    int          ack_mode;
    int          stall_left = 0;
    logic        ack_gate = 1'b0;

`ifdef RMW_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] a;
        logic [31:0] d;
        bit          e;
        int          lat;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[$];

    mem_rmw_adapter #(.MAX_WAIT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en_i     (rd_en_i),
        .wr_en_i     (wr_en_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk = ~clk;

    assign mem_ack_i  = ack_gate & (mem_rd_en_o | mem_wr_en_o);
    assign mem_data_i = mem[mem_addr_o[9:2]];

    // Memory model: commits a write on the edge that sees enable and ack together
    always @(posedge clk) begin
        if (mem_wr_en_o && mem_ack_i) begin
            mem[mem_addr_o[9:2]] <= mem_data_o;
        end
    end

    // Ack generator: 0 zero-wait, 1 never, 2 random 0..3 stall cycles, 3 reads only
    always @(negedge clk) begin
        if (!(mem_rd_en_o || mem_wr_en_o)) begin
            ack_gate <= 1'b0;
        end else begin
            case (ack_mode)
                0: ack_gate <= 1'b1;
                1: ack_gate <= 1'b0;
                3: ack_gate <= mem_rd_en_o;
                default: begin
                    if (stall_left == 0) begin
                        ack_gate   <= 1'b1;
                        stall_left <= $urandom_range(0, 3);
                    end else begin
                        ack_gate   <= 1'b0;
                        stall_left <= stall_left - 1;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit exp_err(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] a);
        bit mis;
        mis = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00));
        return (rd && wr) || (sz == 2'd3) || (ALIGN_CHK && mis);
    endfunction

    // Byte-addressed reference: little-endian, natural container chosen by size
    task automatic ref_apply(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] d);
        int     nb;
        int     base;
        longint v;
        if (exp_err(rd, wr, sz, a)) return;
        nb   = 1 << sz;
        base = int'(a[9:0]) & ~(nb - 1);
        if (wr) begin
            for (int k = 0; k < nb; k++) ref_b[base + k] = d[8*k +: 8];
        end else begin
            v = 0;
            for (int k = 0; k < nb; k++) v += longint'(ref_b[base + k]) << (8 * k);
            if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
            ref_data = v[31:0];
        end
    endtask

    task automatic do_txn(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output bit e, output int en_cnt, output bit to,
                          output bit ack_en, output bit ack_after);
        bit done;
        @(negedge clk);
        rd_en_i = rd; wr_en_i = wr; size_i = sz; unsigned_i = uns; addr_i = a; data_i = d;
        @(posedge clk); #1;
        rd_en_i = 1'b0; wr_en_i = 1'b0;
        lat = 0; e = 1'b0; en_cnt = 0; to = 1'b1; ack_en = 1'b0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (ack_o) begin
                lat = i; e = err_o; to = 1'b0; ack_en = mem_rd_en_o | mem_wr_en_o; done = 1'b1;
            end else begin
                if (mem_rd_en_o || mem_wr_en_o) en_cnt++;
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        ack_after = ack_o;
    endtask

    int          lat, en_cnt, r;
    bit          e, to, ack_en, ack_after, seen, xe;
    bit          rd, wr, uns;
    logic [1:0]  sz;
    logic [31:0] a, d;

    initial begin
        n_tests = 0; n_fail = 0; ack_mode = 0; ref_data = 32'h0;
        rst_n = 1'b0; rd_en_i = 1'b0; wr_en_i = 1'b0; size_i = 2'd0;
        unsigned_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
        for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_ack_o", 32'(ack_o), 32'h0);
        chk("rst_err_o", 32'(err_o), 32'h0);
        chk("rst_busy_o", 32'(busy_o), 32'h0);
        chk("rst_mem_rd_en", 32'(mem_rd_en_o), 32'h0);
        chk("rst_mem_wr_en", 32'(mem_wr_en_o), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: rd, wr, size, uns, addr, data, err, latency, data_o after
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1, 32'h00000000});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 1, 32'hDEADBEEF});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, 1, 32'hDEADBEEF});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h0000005A, 1'b0, 2, 32'hDEADBEEF});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 1, 32'h115A3344});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0000, 1'b0, 1, 32'h115A3344});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        1'b0, 1, 32'hFFFFFF80});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        1'b0, 1, 32'h00000080});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        1'b0, 1, 32'hFFFF80FF});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        1'b0, 1, 32'h000080FF});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234, 1'b0, 2, 32'h000080FF});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 1, 32'h12340000});
        vecs.push_back(vec_t'{1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h55555555, 1'b1, 0, 32'h12340000});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        1'b1, 0, 32'h12340000});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h00000000, 1'b0, 1, 32'h12340000});
`ifdef RMW_ALIGN_CHECK_EN
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000BEEF, 1'b1, 0, 32'h12340000});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        1'b0, 1, 32'h00000000});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        1'b1, 0, 32'h00000000});
`else
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000BEEF, 1'b0, 2, 32'h12340000});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        1'b0, 1, 32'h0000BEEF});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        1'b0, 1, 32'h12340000});
`endif

        foreach (vecs[i]) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].d,
                   lat, e, en_cnt, to, ack_en, ack_after);
            chk($sformatf("vec%0d_timeout", i), 32'(to), 32'h0);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].e));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_data_o", i), data_o, vecs[i].dout);
            chk($sformatf("vec%0d_ack_one_cycle", i), 32'(ack_after), 32'h0);
            if (vecs[i].e) chk($sformatf("vec%0d_no_mem_en", i), 32'(en_cnt), 32'h0);
            ref_apply(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].d);
        end
        chk("mem_0x10_after_table", mem[4], 32'h12340000);

        // Timeout: memory never acks a read
        ack_mode = 1;
        do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, e, en_cnt, to, ack_en, ack_after);
        chk("to_ack_seen", 32'(to), 32'h0);
        chk("to_latency", 32'(lat), 32'd16);
        chk("to_read_cycles", 32'(en_cnt), 32'd16);
        chk("to_err", 32'(e), 32'h1);
        chk("to_enables_in_err", 32'(ack_en), 32'h0);
        chk("to_ack_one_cycle", 32'(ack_after), 32'h0);
        chk("to_data_o_held", data_o, ref_data);

        // Reset during the WRITE leg of a byte store
        ack_mode = 0;
        do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, lat, e, en_cnt, to, ack_en, ack_after);
        ref_apply(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D);
        ack_mode = 3;
        @(negedge clk);
        wr_en_i = 1'b1; size_i = 2'd0; addr_i = 32'h31; data_i = 32'h77;
        @(posedge clk); #1;
        wr_en_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (mem_wr_en_o) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("rstw_reached_write", 32'(seen), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_wr_en_drop", 32'(mem_wr_en_o), 32'h0);
        chk("rstw_busy", 32'(busy_o), 32'h0);
        chk("rstw_ack", 32'(ack_o), 32'h0);
        chk("rstw_data_o", data_o, 32'h0);
        ref_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ack_o || mem_wr_en_o) seen = 1'b1;
        end
        chk("rstw_no_ack_or_write", 32'(seen), 32'h0);
        chk("rstw_mem_unchanged", mem[12], 32'hCAFEF00D);
        ack_mode = 0;
        do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, lat, e, en_cnt, to, ack_en, ack_after);
        ref_apply(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        chk("rstw_readback", data_o, 32'hCAFEF00D);

        // Randomized: preload 64 words, then mixed traffic with random memory stalls
        for (int w = 0; w < 64; w++) begin
            d = $urandom;
            do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * w), d, lat, e, en_cnt, to, ack_en, ack_after);
            ref_apply(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * w), d);
        end
        ack_mode = 2;
        for (int n = 0; n < 300; n++) begin
            r   = $urandom_range(0, 19);
            rd  = (r == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            wr  = (r == 0) ? 1'b1 : !rd;
            sz  = (r == 1) ? 2'd3 : 2'($urandom_range(0, 2));
            uns = ($urandom_range(0, 1) == 1);
            a   = 32'($urandom_range(0, 255));
            d   = $urandom;
            xe  = exp_err(rd, wr, sz, a);
            do_txn(rd, wr, sz, uns, a, d, lat, e, en_cnt, to, ack_en, ack_after);
            ref_apply(rd, wr, sz, uns, a, d);
            chk($sformatf("rnd%0d_timeout", n), 32'(to), 32'h0);
            chk($sformatf("rnd%0d_err", n), 32'(e), 32'(xe));
            chk($sformatf("rnd%0d_data_o", n), data_o, ref_data);
            chk($sformatf("rnd%0d_ack_one_cycle", n), 32'(ack_after), 32'h0);
            chk($sformatf("rnd%0d_enables_in_ack", n), 32'(ack_en), 32'h0);
            if (xe) chk($sformatf("rnd%0d_no_mem_en", n), 32'(en_cnt), 32'h0);
        end
        for (int w = 0; w < 64; w++) begin
            chk($sformatf("rnd_mem_word%0d", w), mem[w],
                {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
